cv32e40p_perm_fault_detector_ft: RTL and testbench

- Producer side of the permanent-fault interface of the fault-tolerant EX stage.
- Watches the per-replica disagreement reports from the ALU and MULT voters.
- Keeps a leaky-bucket error score for each replica: 4 ALUs, 3 MULTs.
- Raises a sticky permanent-fault flag when a score crosses a threshold. These flags drive permanent_faulty_alu/mult inputs of the dispatcher, which selects the replica set.

---
 rtl/cv32e40p_perm_fault_detector_ft.sv | 140 ++++++++++++++
 tb/tb_cv32e40p_perm_fault_detector_ft.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_perm_fault_detector_ft.sv
// Permanent-fault detector for the fault-tolerant EX stage.
// Each ALU/MULT replica keeps a leaky-bucket error score and raises a sticky fault flag once the score crosses THRESHOLD.

module cv32e40p_perm_fault_replica #(
  parameter int CNT_W        = 4,
  parameter int THRESHOLD    = 8,
  parameter int ERR_INC      = 2,
  parameter int DECAY_PERIOD = 16,
  parameter int DECAY_W      = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic vote_i,
  input  logic err_i,
  input  logic clear_i,
  output logic faulty_o,
  output logic new_fault_o
);

  typedef enum logic {HEALTHY = 1'b0, FAULTY = 1'b1} state_e;

  localparam logic [CNT_W:0]   SCORE_MAX  = {1'b0, {CNT_W{1'b1}}};
  localparam logic [CNT_W:0]   INC_EXT    = (CNT_W+1)'(ERR_INC);
  localparam logic [CNT_W:0]   THRESH_EXT = (CNT_W+1)'(THRESHOLD);
  localparam logic [DECAY_W-1:0] DECAY_LAST = DECAY_W'(DECAY_PERIOD - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   score_q, score_d;
  logic [DECAY_W-1:0] decay_q, decay_d;
  logic               new_fault_q, new_fault_d;
  logic [CNT_W:0]     score_sum;
  logic [CNT_W-1:0]   score_sat;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples its pre-edge _d value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HEALTHY;
      score_q     <= '0;
      decay_q     <= '0;
      new_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      decay_q     <= decay_d;
      new_fault_q <= new_fault_d;
    end
  end

  // Widen by one bit so the saturation test sees a carry instead of a wrapped value.
  assign score_sum = {1'b0, score_q} + INC_EXT;
  assign score_sat = (score_sum > SCORE_MAX) ? {CNT_W{1'b1}} : score_sum[CNT_W-1:0];

  // NOTE: every signal gets a default at the top of the block, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    decay_d     = decay_q;
    new_fault_d = 1'b0;
    if (clear_i) begin
      state_d = HEALTHY;
      score_d = '0;
      decay_d = '0;
    end else if (state_q == HEALTHY && vote_i) begin
      if (err_i) begin
        score_d = score_sat;
        decay_d = '0;
        if ({1'b0, score_sat} >= THRESH_EXT) begin
          state_d     = FAULTY;
          new_fault_d = 1'b1;
        end
      end else if (decay_q == DECAY_LAST) begin
        decay_d = '0;
        if (score_q != '0) score_d = score_q - 1'b1;
      end else begin
        decay_d = decay_q + 1'b1;
      end
    end
  end

  always_comb begin
    faulty_o    = (state_q == FAULTY);
    new_fault_o = new_fault_q;
  end

endmodule

module cv32e40p_perm_fault_detector_ft #(
  parameter int CNT_W        = 4,
  parameter int THRESHOLD    = 8,
  parameter int ERR_INC      = 2,
  parameter int DECAY_PERIOD = 16,
  parameter int DECAY_W      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_vote_valid_i,
  input  logic [3:0] alu_active_i,
  input  logic [3:0] alu_err_i,
  input  logic       mult_vote_valid_i,
  input  logic [2:0] mult_active_i,
  input  logic [2:0] mult_err_i,
  input  logic [3:0] clear_alu_i,
  input  logic [2:0] clear_mult_i,
  output logic [3:0] permanent_faulty_alu_o,
  output logic [2:0] permanent_faulty_mult_o,
  output logic [3:0] new_fault_alu_o,
  output logic [2:0] new_fault_mult_o
);

  for (genvar i = 0; i < 4; i++) begin : g_alu
    cv32e40p_perm_fault_replica #(
      .CNT_W(CNT_W), .THRESHOLD(THRESHOLD), .ERR_INC(ERR_INC),
      .DECAY_PERIOD(DECAY_PERIOD), .DECAY_W(DECAY_W)
    ) u_replica (
      .clk         (clk),
      .rst         (rst),
      .vote_i      (alu_vote_valid_i & alu_active_i[i]),
      .err_i       (alu_err_i[i]),
      .clear_i     (clear_alu_i[i]),
      .faulty_o    (permanent_faulty_alu_o[i]),
      .new_fault_o (new_fault_alu_o[i])
    );
  end

  for (genvar i = 0; i < 3; i++) begin : g_mult
    cv32e40p_perm_fault_replica #(
      .CNT_W(CNT_W), .THRESHOLD(THRESHOLD), .ERR_INC(ERR_INC),
      .DECAY_PERIOD(DECAY_PERIOD), .DECAY_W(DECAY_W)
    ) u_replica (
      .clk         (clk),
      .rst         (rst),
      .vote_i      (mult_vote_valid_i & mult_active_i[i]),
      .err_i       (mult_err_i[i]),
      .clear_i     (clear_mult_i[i]),
      .faulty_o    (permanent_faulty_mult_o[i]),
      .new_fault_o (new_fault_mult_o[i])
    );
  end

endmodule

// File: tb/tb_cv32e40p_perm_fault_detector_ft.sv
// Directed self-checking bench for cv32e40p_perm_fault_detector_ft.
// Scores are observed indirectly through how many errors a replica needs before it flags.

module tb_cv32e40p_perm_fault_detector_ft;

  logic       clk;
  logic       rst;
  logic       alu_vote_valid;
  logic [3:0] alu_active, alu_err, clear_alu;
  logic       mult_vote_valid;
  logic [2:0] mult_active, mult_err, clear_mult;
  logic [3:0] pf_alu, nf_alu;
  logic [2:0] pf_mult, nf_mult;

  int n_checks = 0;
  int n_errors = 0;

  cv32e40p_perm_fault_detector_ft dut (
    .clk                     (clk),
    .rst                     (rst),
    .alu_vote_valid_i        (alu_vote_valid),
    .alu_active_i            (alu_active),
    .alu_err_i               (alu_err),
    .mult_vote_valid_i       (mult_vote_valid),
    .mult_active_i           (mult_active),
    .mult_err_i              (mult_err),
    .clear_alu_i             (clear_alu),
    .clear_mult_i            (clear_mult),
    .permanent_faulty_alu_o  (pf_alu),
    .permanent_faulty_mult_o (pf_mult),
    .new_fault_alu_o         (nf_alu),
    .new_fault_mult_o        (nf_mult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge with the given stimulus; inputs return to idle 1 ns after the edge.
  task automatic step(input logic av, input logic [3:0] aa, input logic [3:0] ae,
                      input logic mv, input logic [2:0] ma, input logic [2:0] me,
                      input logic [3:0] ca, input logic [2:0] cm);
    @(negedge clk);
    alu_vote_valid = av;  alu_active = aa;  alu_err = ae;
    mult_vote_valid = mv; mult_active = ma; mult_err = me;
    clear_alu = ca;       clear_mult = cm;
    @(posedge clk);
    #1;
    alu_vote_valid = 1'b0; alu_active = '0; alu_err = '0;
    mult_vote_valid = 1'b0; mult_active = '0; mult_err = '0;
    clear_alu = '0; clear_mult = '0;
  endtask

  task automatic alu_vote(input logic [3:0] a, input logic [3:0] e);
    step(1'b1, a, e, 1'b0, 3'b000, 3'b000, 4'b0000, 3'b000);
  endtask

  task automatic mult_vote(input logic [2:0] a, input logic [2:0] e);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, a, e, 4'b0000, 3'b000);
  endtask

  task automatic idle();
    step(1'b0, 4'b0000, 4'b0000, 1'b0, 3'b000, 3'b000, 4'b0000, 3'b000);
  endtask

  task automatic clear_all();
    step(1'b0, 4'b0000, 4'b0000, 1'b0, 3'b000, 3'b000, 4'b1111, 3'b111);
  endtask

  initial begin
    rst = 1'b1;
    alu_vote_valid = 1'b0; alu_active = '0; alu_err = '0;
    mult_vote_valid = 1'b0; mult_active = '0; mult_err = '0;
    clear_alu = '0; clear_mult = '0;
    #2;
    check("reset_pf_alu",  32'(pf_alu),  32'h0);
    check("reset_pf_mult", 32'(pf_mult), 32'h0);
    check("reset_nf_alu",  32'(nf_alu),  32'h0);
    check("reset_nf_mult", 32'(nf_mult), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: replica 1 scores 2,4,6,8 and flags on the fourth vote
    for (int k = 1; k <= 3; k++) begin
      alu_vote(4'b0111, 4'b0010);
      check($sformatf("t1_pf_vote%0d", k), 32'(pf_alu), 32'h0);
    end
    alu_vote(4'b0111, 4'b0010);
    check("t1_pf_vote4", 32'(pf_alu), 32'h2);
    check("t1_nf_vote4", 32'(nf_alu), 32'h2);
    idle();
    check("t1_nf_after", 32'(nf_alu), 32'h0);
    check("t1_pf_sticky", 32'(pf_alu), 32'h2);
    // A faulty replica ignores further votes: no second pulse
    alu_vote(4'b0111, 4'b0010);
    check("t1_nf_frozen", 32'(nf_alu), 32'h0);
    clear_all();
    check("t1_pf_cleared", 32'(pf_alu), 32'h0);

    // 2: score 6, then 32 clean votes decay it to 4, so two more errors are needed
    repeat (3) alu_vote(4'b0001, 4'b0001);
    check("t2_pf_score6", 32'(pf_alu), 32'h0);
    repeat (32) alu_vote(4'b0001, 4'b0000);
    alu_vote(4'b0001, 4'b0001);
    check("t2_pf_score6_again", 32'(pf_alu), 32'h0);
    alu_vote(4'b0001, 4'b0001);
    check("t2_pf_score8", 32'(pf_alu), 32'h1);
    check("t2_nf_score8", 32'(nf_alu), 32'h1);
    clear_all();

    // 3: inactive replica 3 ignores its err bit, so its score is still 0 afterwards
    repeat (10) alu_vote(4'b0111, 4'b1000);
    check("t3_pf_inactive", 32'(pf_alu), 32'h0);
    repeat (3) alu_vote(4'b1000, 4'b1000);
    check("t3_pf_after3", 32'(pf_alu), 32'h0);
    alu_vote(4'b1000, 4'b1000);
    check("t3_pf_after4", 32'(pf_alu), 32'h8);
    clear_all();

    // 4: clear beats a simultaneous error on MULT replica 2
    repeat (4) mult_vote(3'b111, 3'b100);
    check("t4_pf_mult", 32'(pf_mult), 32'h4);
    check("t4_nf_mult", 32'(nf_mult), 32'h4);
    step(1'b0, 4'b0000, 4'b0000, 1'b1, 3'b111, 3'b100, 4'b0000, 3'b100);
    check("t4_pf_clear", 32'(pf_mult), 32'h0);
    check("t4_nf_clear", 32'(nf_mult), 32'h0);
    idle();
    check("t4_nf_clear_next", 32'(nf_mult), 32'h0);
    mult_vote(3'b111, 3'b100);
    repeat (2) mult_vote(3'b111, 3'b100);
    check("t4_pf_score6", 32'(pf_mult), 32'h0);
    mult_vote(3'b111, 3'b100);
    check("t4_pf_score8", 32'(pf_mult), 32'h4);
    clear_all();

    // 5: async reset mid-cycle while flags are 0101 and replica 1 holds score 6
    repeat (3) alu_vote(4'b0111, 4'b0111);
    alu_vote(4'b0111, 4'b0101);
    check("t5_pf_before", 32'(pf_alu), 32'h5);
    check("t5_nf_before", 32'(nf_alu), 32'h5);
    #2;
    rst = 1'b1;
    #1;
    check("t5_pf_async", 32'(pf_alu), 32'h0);
    check("t5_nf_async", 32'(nf_alu), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) alu_vote(4'b0010, 4'b0010);
    check("t5_pf_restart3", 32'(pf_alu), 32'h0);
    alu_vote(4'b0010, 4'b0010);
    check("t5_pf_restart4", 32'(pf_alu), 32'h2);
    clear_all();

    // 6: both banks flag on the same edge
    repeat (3) step(1'b1, 4'b1111, 4'b1001, 1'b1, 3'b111, 3'b011, 4'b0000, 3'b000);
    check("t6_pf_alu3",  32'(pf_alu),  32'h0);
    check("t6_pf_mult3", 32'(pf_mult), 32'h0);
    step(1'b1, 4'b1111, 4'b1001, 1'b1, 3'b111, 3'b011, 4'b0000, 3'b000);
    check("t6_pf_alu4",  32'(pf_alu),  32'h9);
    check("t6_pf_mult4", 32'(pf_mult), 32'h3);
    check("t6_nf_alu4",  32'(nf_alu),  32'h9);
    check("t6_nf_mult4", 32'(nf_mult), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
